// File: rtl/simd_processing_block.sv
// SIMD processing block: CORES lanes of bf16 ALUs sharing one instruction stream, with an explicit
// fetch/decode FSM, valid/ready instruction fetch, req/ready data memory and illegal-opcode trap.
module simd_processing_block #(
  parameter int unsigned CORES   = 32,
  parameter int unsigned BITS    = 16,
  parameter int unsigned REG_AW  = 8,
  parameter int unsigned IADDR_W = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic [IADDR_W-1:0]      instr_addr,
  output logic                    instr_req,
  input  logic                    instr_valid,
  input  logic [31:0]             instr_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [CORES*BITS-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic [CORES*BITS-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    finished,
  output logic                    error
);
  localparam int unsigned W    = CORES * BITS;
  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [3:0] OpAlu   = 4'd0;
  localparam logic [3:0] OpStore = 4'd1;
  localparam logic [3:0] OpLoad  = 4'd2;
  localparam logic [3:0] OpMovi  = 4'd3;
  localparam logic [3:0] OpBnz   = 4'd4;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StAluWait, StWb, StMem, StHalt} state_e;

  // Lane ALU: ctrl 0 add, 1 sub (bf16, truncating, subnormals flushed), 2 and, 3 or, 4 xor, else ra.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [10:0] mx, my;
    logic [11:0] s;
    logic [7:0]  d;
    logic [8:0]  e;
    logic [3:0]  lz;
    x = a;
    y = b;
    if (b[14:0] > a[14:0]) begin
      x = b;
      y = a;
    end
    mx = {1'b1, x[6:0], 3'b000};
    d  = x[14:7] - y[14:7];
    my = (d > 8'd10) ? 11'd0 : ({1'b1, y[6:0], 3'b000} >> d);
    e  = {1'b0, x[14:7]};
    lz = 4'd0;
    s  = 12'd0;
    if (x[14:7] == 8'd0) return 16'h0000;
    if (y[14:7] == 8'd0) return x;
    if (x[15] == y[15]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[11]) begin
        s = s >> 1;
        e = e + 9'd1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == 12'd0) return 16'h0000;
      for (int i = 0; i < 11; i++) begin
        if (!s[10]) begin
          s  = s << 1;
          lz = lz + 4'd1;
        end
      end
      if (e <= {5'd0, lz}) return 16'h0000;
      e = e - {5'd0, lz};
    end
    if (e >= 9'd255) return {x[15], 8'hFF, 7'd0};
    return {x[15], e[7:0], s[9:3]};
  endfunction

  function automatic logic [15:0] alu_lane(input logic [3:0] ctrl, input logic [15:0] a,
                                           input logic [15:0] b);
    case (ctrl)
      4'd0:    return bf16_add(a, b);
      4'd1:    return bf16_add(a, b ^ 16'h8000);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  state_e               state_q;
  logic [IADDR_W-1:0]   ip_q;
  logic [31:0]          instr_q;
  logic [LatW-1:0]      lat_cnt_q;
  logic                 instr_req_q, mem_req_q, mem_we_q, busy_q, finished_q, error_q;
  logic [15:0]          mem_addr_q;
  logic [W-1:0]         mem_wdata_q;

  logic [W-1:0]         rf_q [2**REG_AW];
  logic [W-1:0]         alu_pipe_q [ALU_LAT];

  logic [3:0]           op, ctrl;
  logic [REG_AW-1:0]    rd, ra, rb;
  logic [15:0]          imm;
  logic [W-1:0]         rd_vec, ra_vec, rb_vec, alu_res, movi_vec;
  logic                 rf_we;
  logic [W-1:0]         rf_wdata;

  assign op     = instr_q[31:28];
  assign ctrl   = instr_q[27:24];
  assign rd     = instr_q[16 +: REG_AW];
  assign ra     = instr_q[8 +: REG_AW];
  assign rb     = instr_q[0 +: REG_AW];
  assign imm    = instr_q[15:0];
  assign rd_vec = rf_q[rd];
  assign ra_vec = rf_q[ra];
  assign rb_vec = rf_q[rb];

  for (genvar l = 0; l < CORES; l++) begin : g_lane
    assign alu_res[l*BITS +: BITS]  = alu_lane(ctrl, ra_vec[l*BITS +: BITS], rb_vec[l*BITS +: BITS]);
    assign movi_vec[l*BITS +: BITS] = imm;
  end

  // Operands stay stable from DECODE to WB, so the pipe output is valid whenever WB reads it.
  always_ff @(posedge clock) begin
    alu_pipe_q[0] <= alu_res;
    for (int i = 1; i < ALU_LAT; i++) alu_pipe_q[i] <= alu_pipe_q[i-1];
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_pipe_q[ALU_LAT-1];
    if (state_q == StWb) begin
      rf_we = 1'b1;
      if (op == OpMovi) rf_wdata = movi_vec;
    end else if (state_q == StMem && mem_ready && !mem_we_q) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rf_we) rf_q[rd] <= rf_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ip_q        <= '0;
      instr_q     <= '0;
      lat_cnt_q   <= '0;
      instr_req_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StFetch;
            instr_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StFetch: begin
          if (instr_valid) begin
            instr_q     <= instr_data;
            instr_req_q <= 1'b0;
            state_q     <= StDecode;
          end
        end
        StDecode: begin
          if (instr_q == 32'h0) begin
            state_q    <= StHalt;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            case (op)
              OpAlu: begin
                lat_cnt_q <= '0;
                state_q   <= StAluWait;
              end
              OpMovi: state_q <= StWb;
              OpBnz: begin
                ip_q        <= (|rd_vec[BITS-1:0]) ? imm[IADDR_W-1:0] : ip_q + 1'b1;
                instr_req_q <= 1'b1;
                state_q     <= StFetch;
              end
              OpStore, OpLoad: begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (op == OpStore);
                mem_addr_q  <= (op == OpStore) ? rb_vec[15:0] : ra_vec[15:0];
                mem_wdata_q <= rd_vec;
                state_q     <= StMem;
              end
              default: begin
                error_q    <= 1'b1;
                busy_q     <= 1'b0;
                finished_q <= 1'b1;
                state_q    <= StHalt;
              end
            endcase
          end
        end
        StAluWait: begin
          if (lat_cnt_q == LatW'(ALU_LAT - 1)) state_q <= StWb;
          else lat_cnt_q <= lat_cnt_q + 1'b1;
        end
        StWb: begin
          ip_q        <= ip_q + 1'b1;
          instr_req_q <= 1'b1;
          state_q     <= StFetch;
        end
        StMem: begin
          if (mem_ready) begin
            mem_req_q   <= 1'b0;
            ip_q        <= ip_q + 1'b1;
            instr_req_q <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_addr = ip_q;
  assign instr_req  = instr_req_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign error      = error_q;

endmodule

// File: tb/tb_simd_processing_block.sv
// Directed bench for simd_processing_block: ROM/memory responders with programmable wait states.
module tb_simd_processing_block;
  localparam int unsigned W = 512;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   instr_addr;
  logic          instr_req;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr_data = 32'h0;
  logic          mem_req, mem_we;
  logic [15:0]   mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_ready = 1'b0;
  logic [W-1:0]  mem_rdata = '0;
  logic          busy, finished, error;

  simd_processing_block dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .instr_addr  (instr_addr),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .finished    (finished),
    .error       (error)
  );

  always #5 clock = ~clock;

  logic [31:0]  rom [64];
  int unsigned  ifetch_delay = 0, mem_delay = 0, iwait = 0, mwait = 0, mreq_cycles = 0;
  int unsigned  unstable = 0, tx_cnt = 0, busy_drop = 0;
  logic [W-1:0] load_data = '0;
  logic [15:0]  first_addr;
  logic         first_we;
  int unsigned  tx_cycles [8];
  logic         tx_we [8];
  logic [15:0]  tx_addr [8];
  logic [W-1:0] tx_data [8];
  int           errors = 0, checks = 0;

  // Instruction ROM and data memory responders, driven away from the active edge.
  always @(negedge clock) begin
    if (instr_req) begin
      if (iwait >= ifetch_delay) begin
        instr_valid = 1'b1;
        instr_data  = rom[instr_addr[5:0]];
        iwait       = 0;
      end else begin
        instr_valid = 1'b0;
        instr_data  = 32'hDEAD_BEEF;
        iwait++;
      end
    end else begin
      instr_valid = 1'b0;
      iwait       = 0;
    end
    if (mem_req) begin
      if (mreq_cycles == 0) begin
        first_addr = mem_addr;
        first_we   = mem_we;
      end else if (mem_addr != first_addr || mem_we != first_we) begin
        unstable++;
      end
      mreq_cycles++;
      if (mwait >= mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = load_data;
        if (tx_cnt < 8) begin
          tx_cycles[tx_cnt] = mreq_cycles;
          tx_we[tx_cnt]     = mem_we;
          tx_addr[tx_cnt]   = mem_addr;
          tx_data[tx_cnt]   = mem_wdata;
        end
        tx_cnt++;
        mwait       = 0;
        mreq_cycles = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = ~load_data;
        mwait++;
      end
    end else begin
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      mwait       = 0;
      mreq_cycles = 0;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    return {32{v}};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_prog(input bit with_reset);
    int cyc;
    busy_drop = 0;
    tx_cnt    = 0;
    unstable  = 0;
    if (with_reset) do_reset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clock);
      if (!finished && !busy) busy_drop++;
      cyc++;
    end
    check("run_finished", finished, 1);
  endtask

  task automatic load_store_prog();
    clear_rom();
    rom[0] = 32'h3001_3F80;  // MOVI r1, 1.0
    rom[1] = 32'h3002_4000;  // MOVI r2, 2.0
    rom[2] = 32'h3004_0010;  // MOVI r4, 0x0010
    rom[3] = 32'h0003_0102;  // ADD  r3 = r1 + r2
    rom[4] = 32'h1003_0004;  // STORE r3 -> [r4]
    rom[5] = 32'h0000_0000;  // HALT
  endtask

  task automatic check_store_prog(input string tag);
    check({tag, "_txcnt"}, W'(tx_cnt), W'(1));
    check({tag, "_we"}, W'(tx_we[0]), W'(1));
    check({tag, "_addr"}, W'(tx_addr[0]), W'(16'h0010));
    check({tag, "_data"}, tx_data[0], rep(16'h4040));
    check({tag, "_error"}, W'(error), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] pat;
    int           req_seen;

    // Reset state
    #1;
    check("rst_ctl", W'({instr_req, mem_req, mem_we, busy, finished, error}), W'(0));
    check("rst_iaddr", W'(instr_addr), W'(0));
    check("rst_maddr", W'(mem_addr), W'(0));
    check("rst_wdata", mem_wdata, '0);

    // Zero-wait MOVI/ADD/STORE
    load_store_prog();
    run_prog(1'b1);
    check_store_prog("zw");
    repeat (3) @(negedge clock);
    check("zw_halt_noreq", W'(instr_req), W'(0));

    // Same program with 3 wait states per fetch
    ifetch_delay = 3;
    run_prog(1'b1);
    check_store_prog("iw");
    check("iw_busy_drop", W'(busy_drop), W'(0));
    ifetch_delay = 0;

    // LOAD held off 5 cycles, then stored back to observe the written register
    for (int l = 0; l < 32; l++) pat[l*16 +: 16] = 16'hA000 + 16'(l);
    load_data = pat;
    mem_delay = 5;
    clear_rom();
    rom[0] = 32'h3004_0020;  // MOVI r4, 0x0020
    rom[1] = 32'h2005_0400;  // LOAD r5 <- [r4]
    rom[2] = 32'h1005_0004;  // STORE r5 -> [r4]
    rom[3] = 32'h0000_0000;
    run_prog(1'b1);
    check("ld_txcnt", W'(tx_cnt), W'(2));
    check("ld_we", W'(tx_we[0]), W'(0));
    check("ld_addr", W'(tx_addr[0]), W'(16'h0020));
    check("ld_req_cycles", W'(tx_cycles[0]), W'(6));
    check("ld_stable", W'(unstable), W'(0));
    check("ld_rd_value", tx_data[1], pat);
    mem_delay = 0;
    load_data = '0;

    // BNZ loop: store r1, r1 -= 1.0, branch back while nonzero
    clear_rom();
    rom[0] = 32'h3001_4040;  // MOVI r1, 3.0
    rom[1] = 32'h3002_3F80;  // MOVI r2, 1.0
    rom[2] = 32'h3004_0030;  // MOVI r4, 0x0030
    rom[3] = 32'h1001_0004;  // STORE r1 -> [r4]
    rom[4] = 32'h0101_0102;  // SUB  r1 = r1 - r2
    rom[5] = 32'h4001_0003;  // BNZ  r1, 3
    rom[6] = 32'h0000_0000;
    run_prog(1'b1);
    check("bnz_iters", W'(tx_cnt), W'(3));
    check("bnz_it0", tx_data[0], rep(16'h4040));
    check("bnz_it1", tx_data[1], rep(16'h4000));
    check("bnz_it2", tx_data[2], rep(16'h3F80));
    check("bnz_error", W'(error), W'(0));

    // Illegal opcode traps to HALT; start is ignored afterwards
    clear_rom();
    rom[0] = 32'h5000_0000;
    run_prog(1'b1);
    check("ill_error", W'(error), W'(1));
    check("ill_busy", W'(busy), W'(0));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (instr_req || busy) req_seen++;
    end
    check("ill_no_refetch", W'(req_seen), W'(0));
    check("ill_sticky", W'({finished, error}), W'(2'b11));

    // Reset during a MEM wait, then a fresh start from ip 0
    load_store_prog();
    mem_delay = 20;
    do_reset();
    tx_cnt = 0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 200 && !mem_req; i++) @(negedge clock);
    check("mr_reached_mem", W'(mem_req), W'(1));
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mr_ctl", W'({instr_req, mem_req, mem_we, busy, finished, error}), W'(0));
    check("mr_addr", W'({instr_addr, mem_addr}), W'(0));
    check("mr_wdata", mem_wdata, '0);
    @(negedge clock);
    reset_n   = 1'b1;
    mem_delay = 0;
    @(negedge clock);
    run_prog(1'b0);
    check_store_prog("mr_rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
